// File: rtl/seat_scan.sv
// rtl/seat_scan.sv - seat-table sweeper: reads every seat once, clears over-limit "away" seats,
// and publishes per-state counts when the sweep finishes.
module seat_scan #(
  parameter int SEATS = 32,
  parameter int AW    = 5,
  parameter int TW    = 11
) (
  input  logic          clk_scan,
  input  logic          rst_scan,
  input  logic          start_scan,
  input  logic [TW-1:0] Time_scan,
  input  logic [TW-1:0] limit_time,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [TW-1:0] rd_time,
  input  logic [1:0]    rd_state,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [1:0]    wr_state,
  output logic          busy_scan,
  output logic          done_scan,
  output logic [5:0]    free_cnt,
  output logic [5:0]    away_cnt,
  output logic [5:0]    rsv_cnt,
  output logic [5:0]    occ_cnt,
  output logic [5:0]    expired_cnt
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(SEATS - 1);

  state_t        state, next_state;
  logic [AW-1:0] idx, idx_next;
  logic          accept;
  logic          rd_en_d, busy_d, done_d;
  logic [AW-1:0] rd_addr_d;
  logic [TW-1:0] now_r, lim_r;

  logic          vld;
  logic [AW-1:0] vaddr;
  logic [TW-1:0] elapsed;
  logic          expired;
  logic [5:0]    free_acc, away_acc, rsv_acc, occ_acc, exp_acc;

  assign accept   = start_scan && (state == IDLE || state == DONE);
  assign wr_state = 2'd0;

  always_ff @(posedge clk_scan or posedge rst_scan) begin
    if (rst_scan) begin
      state     <= IDLE;
      idx       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy_scan <= 1'b0;
      done_scan <= 1'b0;
      now_r     <= '0;
      lim_r     <= '0;
    end else begin
      state     <= next_state;
      idx       <= idx_next;
      rd_en     <= rd_en_d;
      rd_addr   <= rd_addr_d;
      busy_scan <= busy_d;
      done_scan <= done_d;
      if (accept) begin
        now_r <= Time_scan;
        lim_r <= limit_time;
      end
    end
  end

  // idx walks seat addresses in READ and counts the two drain cycles in DRAIN
  always_comb begin
    next_state = state;
    idx_next   = idx;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          next_state = READ;
          idx_next   = '0;
        end else begin
          next_state = IDLE;
        end
      end
      READ: begin
        if (idx == LAST) begin
          next_state = DRAIN;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      DRAIN: begin
        if (idx == AW'(1)) begin
          next_state = DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en_d   = (next_state == READ);
    rd_addr_d = rd_en_d ? idx_next : '0;
    busy_d    = (next_state == READ) || (next_state == DRAIN);
    done_d    = (next_state == DONE);
  end

  // elapsed wraps modulo 2^TW so a timestamp from before the counter rollover still ages correctly
  assign elapsed = now_r - rd_time;
  assign expired = vld && (rd_state == 2'd1) && (elapsed > lim_r);

  always_ff @(posedge clk_scan or posedge rst_scan) begin
    if (rst_scan) begin
      vld         <= 1'b0;
      vaddr       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      free_acc    <= '0;
      away_acc    <= '0;
      rsv_acc     <= '0;
      occ_acc     <= '0;
      exp_acc     <= '0;
      free_cnt    <= '0;
      away_cnt    <= '0;
      rsv_cnt     <= '0;
      occ_cnt     <= '0;
      expired_cnt <= '0;
    end else begin
      vld   <= rd_en;
      vaddr <= rd_addr;
      wr_en <= expired;
      if (expired) wr_addr <= vaddr;

      if (accept) begin
        free_acc <= '0;
        away_acc <= '0;
        rsv_acc  <= '0;
        occ_acc  <= '0;
        exp_acc  <= '0;
      end else if (vld) begin
        if (expired) begin
          free_acc <= free_acc + 6'd1;
          exp_acc  <= exp_acc + 6'd1;
        end else begin
          case (rd_state)
            2'd0:    free_acc <= free_acc + 6'd1;
            2'd1:    away_acc <= away_acc + 6'd1;
            2'd2:    rsv_acc  <= rsv_acc + 6'd1;
            default: occ_acc  <= occ_acc + 6'd1;
          endcase
        end
      end

      if (next_state == DONE) begin
        free_cnt    <= free_acc;
        away_cnt    <= away_acc;
        rsv_cnt     <= rsv_acc;
        occ_cnt     <= occ_acc;
        expired_cnt <= exp_acc;
      end
    end
  end

endmodule
